aes128_inv_core_masked: RTL



---
 rtl/aes128_inv_core_masked.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/aes128_inv_core_masked.sv
// Iterative masked AES-128 decryption: 256-cycle table/key-expansion INIT, then one inverse round per cycle.
// Latency 266 cycles from start to done; start is ignored while busy, and there is no output backpressure.
module aes128_inv_core_masked (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   input  logic [127:0] mask,
   input  logic         fault_inject,
   output logic [127:0] plaintext,
   output logic         done,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, INIT, ROUND} fsm_t;

   fsm_t         cur_st, nxt_st;
   logic [7:0]   m_reg;
   logic [127:0] state_reg;
   logic [127:0] rk_reg;
   logic [7:0]   cnt;
   logic [3:0]   rc;
   logic [7:0]   inv_tbl [256];

   logic unused_mask;
   assign unused_mask = ^mask[127:8];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 = product of x^(2^k) for k = 1..7; maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq, r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = gf_inv(a);
      return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   // One SubWord unit serves both the forward expansion (INIT) and the inverse schedule (ROUND)
   logic [31:0] w0, w1, w2, w3, v0, v1, v2, v3, n0, n1, n2, n3;
   logic [31:0] sub_in, rot_in, sw;
   logic [7:0]  rcon_b;

   always_comb begin
      {w0, w1, w2, w3} = rk_reg;
      v3     = w3 ^ w2;
      v2     = w2 ^ w1;
      v1     = w1 ^ w0;
      sub_in = (cur_st == ROUND) ? v3 : w3;
      rcon_b = (cur_st == ROUND) ? rcon(rc + 4'd1) : rcon(cnt[3:0] + 4'd1);
      rot_in = {sub_in[23:0], sub_in[31:24]};
      sw     = {sbox(rot_in[31:24]), sbox(rot_in[23:16]), sbox(rot_in[15:8]), sbox(rot_in[7:0])};
      v0     = w0 ^ sw ^ {rcon_b, 24'h0};
      n0     = v0;
      n1     = w1 ^ n0;
      n2     = w2 ^ n1;
      n3     = w3 ^ n2;
   end

   logic [127:0] sub_sr, ark, mixed, t;

   always_comb begin
      sub_sr = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sub_sr[127-8*(4*c+r) -: 8] = inv_tbl[state_reg[127-8*(4*((c+4-r)%4)+r) -: 8]];
         end
      end
      ark   = sub_sr ^ {v0, v1, v2, v3};
      mixed = ark;
      if (rc != 4'd0) begin
         for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
         end
      end
      t = mixed;
      if (fault_inject && rc == 4'd5) t[0] = ~mixed[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_st <= IDLE;
      else     cur_st <= nxt_st;
   end

   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         IDLE:    if (start && !busy) nxt_st = INIT;
         INIT:    if (cnt == 8'd255)  nxt_st = ROUND;
         ROUND:   if (rc == 4'd0)     nxt_st = IDLE;
         default: nxt_st = IDLE;
      endcase
   end

   // The masked table is rebuilt from scratch on every start, so it needs no reset
   always_ff @(posedge clk) begin
      if (cur_st == INIT) inv_tbl[cnt] <= inv_sbox(cnt ^ m_reg) ^ m_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_reg     <= 8'h00;
         state_reg <= '0;
         rk_reg    <= '0;
         cnt       <= 8'h00;
         rc        <= 4'd0;
         plaintext <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (cur_st)
            IDLE: begin
               if (start && !busy) begin
                  m_reg     <= mask[7:0];
                  state_reg <= ciphertext ^ {16{mask[7:0]}};
                  rk_reg    <= key;
                  cnt       <= 8'h00;
                  busy      <= 1'b1;
               end
            end
            INIT: begin
               cnt <= cnt + 8'd1;
               if (cnt < 8'd10) rk_reg <= {n0, n1, n2, n3};
               if (cnt == 8'd255) begin
                  state_reg <= state_reg ^ rk_reg;
                  rc        <= 4'd9;
               end
            end
            ROUND: begin
               state_reg <= t;
               rk_reg    <= {v0, v1, v2, v3};
               if (rc == 4'd0) begin
                  plaintext <= t ^ {16{m_reg}};
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  rc <= rc - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
